// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline-stage register: state codes and occupancy width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Occupancy output width: counts 0, 1 or 2 held entries.
  localparam int OCC_W = 2;

  // Stage state. The encoding equals the number of held entries, which lets the
  // occupancy decode stay trivial. ST_FULL is never entered when the skid slot is absent.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Number of held entries for a given state.
  function automatic logic [OCC_W-1:0] occ_of(input state_e s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg_slot.sv
// Payload register with load enable, used for the main and skid slots of a stage.
// Latency: loaded value visible one cycle after load_i.
// Backpressure: none; the owning stage decides when to load.
module pipe_slot #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next value: take the new payload only when loading, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = d_i;
    end
  end

  // Payload storage; reset restores the configured reset value immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with synchronous flush and optional skid slot.
// Latency: one cycle from in_fire to Out_Valid/Out_Data.
// Backpressure: with skid, In_Ready is registered (low only when two beats held); without, In_Ready = !Out_Valid | Out_Ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SKID_EN     = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_Data,
  output logic [OCC_W-1:0] Occupancy
);

  state_e           state_q;
  state_e           state_d;

  logic             in_fire;
  logic             out_fire;

  logic             main_ld;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign in_fire  = In_Valid & In_Ready;
  assign out_fire = Out_Valid & Out_Ready;

  // Output decode. With the skid slot, In_Ready comes from the state register
  // alone so the downstream stall never reaches the upstream ready in the same cycle.
  always_comb begin
    Out_Valid = (state_q != ST_EMPTY);
    Occupancy = occ_of(state_q);
    if (SKID_EN != 0) begin
      In_Ready = (state_q != ST_FULL);
    end else begin
      In_Ready = (state_q == ST_EMPTY) | Out_Ready;
    end
  end

  // Next-state and main-slot load control. Flush wins over everything except
  // reset and drops the valids only; payload registers keep their contents.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire && (SKID_EN != 0)) begin
            // Downstream stalled: park the younger beat in the skid slot.
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // In_Ready is low here, so only the drain path exists.
          if (out_fire) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Main slot refills from upstream, or from the skid slot when draining FULL.
  always_comb begin
    main_d = In_Data;
    if (main_from_skid) begin
      main_d = skid_q;
    end
  end

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_slot #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .Clock  (Clock),
    .Reset  (Reset),
    .load_i (main_ld),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  if (SKID_EN != 0) begin : g_skid
    logic skid_ld;

    // Skid captures only when a beat arrives in ONE while downstream stalls.
    assign skid_ld = ~Flush & (state_q == ST_ONE) & in_fire & ~out_fire;

    pipe_slot #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_skid (
      .Clock  (Clock),
      .Reset  (Reset),
      .load_i (skid_ld),
      .d_i    (In_Data),
      .q_o    (skid_q)
    );
  end else begin : g_noskid
    assign skid_q = RESET_VALUE;
  end

  assign Out_Data = main_q;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int          W    = 32;
  localparam logic [31:0] RV_A = 32'hDEAD_BEEF;
  localparam logic [31:0] RV_B = 32'h0000_0BAD;

  logic clk = 1'b0;
  logic rst;

  // DUT a: skid slot present
  logic        a_flush, a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_id, a_od;
  logic [1:0]  a_occ;

  // DUT b: no skid slot
  logic        b_flush, b_iv, b_ir, b_ov, b_or;
  logic [31:0] b_id, b_od;
  logic [1:0]  b_occ;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV_A), .SKID_EN(1)) dut_a (
    .Clock(clk), .Reset(rst), .Flush(a_flush),
    .In_Valid(a_iv), .In_Ready(a_ir), .In_Data(a_id),
    .Out_Valid(a_ov), .Out_Ready(a_or), .Out_Data(a_od),
    .Occupancy(a_occ)
  );

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV_B), .SKID_EN(0)) dut_b (
    .Clock(clk), .Reset(rst), .Flush(b_flush),
    .In_Valid(b_iv), .In_Ready(b_ir), .In_Data(b_id),
    .Out_Valid(b_ov), .Out_Ready(b_or), .Out_Data(b_od),
    .Occupancy(b_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_iv = 0; a_or = 0; a_id = '0;
    b_flush = 0; b_iv = 0; b_or = 0; b_id = '0;
    #1;
    chk("rst_a_ov",  {31'd0, a_ov}, 32'd0);
    chk("rst_a_occ", {30'd0, a_occ}, 32'd0);
    chk("rst_a_ir",  {31'd0, a_ir}, 32'd1);
    chk("rst_a_od",  a_od, RV_A);
    chk("rst_b_od",  b_od, RV_B);
    chk("rst_b_ir",  {31'd0, b_ir}, 32'd1);
    #11 rst = 1'b0;
    tick();
    chk("post_rst_a_ov", {31'd0, a_ov}, 32'd0);

    // Streaming 1..4 with Out_Ready held high
    a_or = 1; a_iv = 1; a_id = 32'd1;
    tick();
    chk("stream_od1", a_od, 32'd1);
    chk("stream_ov1", {31'd0, a_ov}, 32'd1);
    chk("stream_occ1", {30'd0, a_occ}, 32'd1);
    for (int i = 2; i <= 4; i++) begin
      a_id = i;
      tick();
      chk("stream_od",  a_od, i);
      chk("stream_occ", {30'd0, a_occ}, 32'd1);
      chk("stream_ir",  {31'd0, a_ir}, 32'd1);
    end
    a_iv = 0;
    tick();
    chk("stream_drain_ov", {31'd0, a_ov}, 32'd0);
    chk("stream_drain_occ", {30'd0, a_occ}, 32'd0);

    // Stall fill: 0x10 accepted, then 0x20 into skid, 0x30 held upstream
    a_iv = 1; a_id = 32'h10;
    tick();
    chk("fill_od10", a_od, 32'h10);
    a_or = 0; a_id = 32'h20;
    #1 chk("fill_ir_one", {31'd0, a_ir}, 32'd1);
    tick();
    chk("fill_occ2", {30'd0, a_occ}, 32'd2);
    chk("fill_ir0",  {31'd0, a_ir}, 32'd0);
    chk("fill_od_a", a_od, 32'h10);
    a_id = 32'h30;
    tick();
    chk("fill_hold_occ", {30'd0, a_occ}, 32'd2);
    chk("fill_hold_od",  a_od, 32'h10);
    tick();
    chk("fill_hold_od2", a_od, 32'h10);
    chk("fill_hold_ov",  {31'd0, a_ov}, 32'd1);
    a_or = 1;
    #1 chk("fill_ir_reg", {31'd0, a_ir}, 32'd0);
    tick();
    chk("drain_od20",  a_od, 32'h20);
    chk("drain_occ1",  {30'd0, a_occ}, 32'd1);
    chk("drain_ir1",   {31'd0, a_ir}, 32'd1);
    tick();
    chk("drain_od30",  a_od, 32'h30);
    a_iv = 0;
    tick();
    chk("drain_empty", {31'd0, a_ov}, 32'd0);

    // Reset while FULL
    a_or = 0; a_iv = 1; a_id = 32'hAAAA_0001;
    tick();
    a_id = 32'hAAAA_0002;
    tick();
    chk("rmid_occ2", {30'd0, a_occ}, 32'd2);
    a_iv = 0;
    #2 rst = 1'b1;
    #1;
    chk("rmid_ov",  {31'd0, a_ov}, 32'd0);
    chk("rmid_occ", {30'd0, a_occ}, 32'd0);
    chk("rmid_ir",  {31'd0, a_ir}, 32'd1);
    chk("rmid_od",  a_od, RV_A);
    #2 rst = 1'b0;
    a_or = 1;
    tick();
    chk("rmid_after_ov", {31'd0, a_ov}, 32'd0);
    chk("rmid_after_od", a_od, RV_A);

    // Flush collision in ONE
    a_or = 0; a_iv = 1; a_id = 32'h55;
    tick();
    chk("fc_od55", a_od, 32'h55);
    a_flush = 1; a_id = 32'h66;
    tick();
    a_flush = 0; a_iv = 0;
    chk("fc_ov",  {31'd0, a_ov}, 32'd0);
    chk("fc_occ", {30'd0, a_occ}, 32'd0);
    chk("fc_ir",  {31'd0, a_ir}, 32'd1);
    chk("fc_od_kept", a_od, 32'h55);
    a_or = 1;
    tick();
    chk("fc_ov_later", {31'd0, a_ov}, 32'd0);

    // Flush from FULL, then 0x77 emerges first
    a_or = 0; a_iv = 1; a_id = 32'h81;
    tick();
    a_id = 32'h82;
    tick();
    chk("ff_occ2", {30'd0, a_occ}, 32'd2);
    a_flush = 1; a_iv = 0;
    tick();
    chk("ff_occ0", {30'd0, a_occ}, 32'd0);
    chk("ff_ov0",  {31'd0, a_ov}, 32'd0);
    chk("ff_ir1",  {31'd0, a_ir}, 32'd1);
    a_flush = 0; a_iv = 1; a_id = 32'h77; a_or = 1;
    tick();
    chk("ff_od77", a_od, 32'h77);
    chk("ff_ov77", {31'd0, a_ov}, 32'd1);
    a_iv = 0;
    tick();
    chk("ff_after_ov", {31'd0, a_ov}, 32'd0);

    // No-skid variant
    chk("ns_ir_empty", {31'd0, b_ir}, 32'd1);
    b_iv = 1; b_id = 32'h10; b_or = 1;
    tick();
    chk("ns_od10", b_od, 32'h10);
    b_or = 0; b_id = 32'h20;
    #1 chk("ns_ir_low", {31'd0, b_ir}, 32'd0);
    b_or = 1;
    #1 chk("ns_ir_high", {31'd0, b_ir}, 32'd1);
    b_or = 0;
    tick();
    chk("ns_hold_od",  b_od, 32'h10);
    chk("ns_hold_occ", {30'd0, b_occ}, 32'd1);
    tick();
    chk("ns_hold_od2", b_od, 32'h10);
    chk("ns_hold_occ2", {30'd0, b_occ}, 32'd1);
    b_or = 1;
    tick();
    chk("ns_od20",  b_od, 32'h20);
    chk("ns_occ20", {30'd0, b_occ}, 32'd1);
    b_iv = 0;
    tick();
    chk("ns_empty_ov",  {31'd0, b_ov}, 32'd0);
    chk("ns_empty_occ", {30'd0, b_occ}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pipe_stage_reg
